count_dir_ctrl: RTL and testbench

Control stage directly upstream of the 4-bit up/down counter. Debounces two raw pushbuttons and drives the counter's mode (direction) and clr inputs. Optionally consumes the counter's tc to reverse direction automatically at each terminal count (ping-pong mode). Also reports debounced button levels and a saturating count of auto-reversals.

---
 rtl/count_dir_ctrl.sv | 178 +++++++++++++++++
 tb/tb_count_dir_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/count_dir_ctrl.sv
// ---------------------------------------------------------------------------
// count_dir_ctrl
//
// Control stage that sits in front of a 4-bit up/down counter. It debounces
// two raw pushbuttons and uses the clean presses to drive the counter's
// direction (mode) and clear (cnt_clr). When auto_rev is set, every rising
// edge of the counter's terminal-count flag also reverses the direction,
// which gives ping-pong counting. Auto-reversals are counted in a saturating
// 8-bit register.
//
// Parameters
//   SYNC_STAGES  synchronizer flops per raw button (>= 2)
//   DB_CYCLES    consecutive stable synchronized samples needed to accept a
//                press or a release (>= 1)
//   MODE_INIT    mode after reset or clear press (0 = up, 1 = down)
//
// Ports
//   clk         in   rising-edge system clock
//   clr         in   synchronous active-high reset
//   btn_dir     in   raw direction-toggle button (asynchronous, bouncy)
//   btn_clr     in   raw clear button (asynchronous, bouncy)
//   auto_rev    in   1 = reverse mode on each rising edge of tc
//   tc          in   terminal-count flag from the counter (clk domain)
//   mode        out  counter direction (0 up, 1 down)
//   cnt_clr     out  one-cycle clear to the counter, active high
//   btn_dir_db  out  debounced level of btn_dir
//   btn_clr_db  out  debounced level of btn_clr
//   rev_cnt     out  number of auto-reversals, saturates at 255
// ---------------------------------------------------------------------------
module count_dir_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter bit MODE_INIT   = 1'b0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn_dir,
  input  logic       btn_clr,
  input  logic       auto_rev,
  input  logic       tc,
  output logic       mode,
  output logic       cnt_clr,
  output logic       btn_dir_db,
  output logic       btn_clr_db,
  output logic [7:0] rev_cnt
);

  // The debounce counter only has to hold values 1 .. DB_CYCLES-1.
  localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    PRESSED,
    RELEASE_CHK
  } db_state_t;

  // Bit 0 = direction button, bit 1 = clear button.
  logic [1:0] raw;
  logic [1:0] db_lvl;
  logic [1:0] press;

  assign raw = {btn_clr, btn_dir};

  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic [SYNC_STAGES-1:0] sync_q;
    db_state_t              state;
    logic [CW-1:0]          cnt;
    logic                   lvl_q;
    logic                   press_q;
    logic                   s;

    assign s         = sync_q[SYNC_STAGES-1];
    assign db_lvl[b] = lvl_q;
    assign press[b]  = press_q;

    // NOTE: all state here is updated with non-blocking assignments so every
    // flop samples the values from before the edge, which is what makes the
    // synchronizer a real shift chain instead of a single collapsed flop.
    always_ff @(posedge clk) begin
      if (clr) begin
        sync_q  <= '0;
        state   <= RELEASED;
        cnt     <= '0;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], raw[b]};
        press_q <= 1'b0;
        case (state)
          RELEASED: begin
            if (s) begin
              // The entering sample already counts as the first stable one.
              if (DB_CYCLES == 1) begin
                state   <= PRESSED;
                lvl_q   <= 1'b1;
                press_q <= 1'b1;
              end else begin
                state <= PRESS_CHK;
                cnt   <= CW'(1);
              end
            end
          end
          PRESS_CHK: begin
            if (!s) begin
              state <= RELEASED;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
              state   <= PRESSED;
              lvl_q   <= 1'b1;
              press_q <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          PRESSED: begin
            if (!s) begin
              if (DB_CYCLES == 1) begin
                state <= RELEASED;
                lvl_q <= 1'b0;
              end else begin
                state <= RELEASE_CHK;
                cnt   <= CW'(1);
              end
            end
          end
          RELEASE_CHK: begin
            if (s) begin
              // Release bounce: back to pressed without a new press pulse.
              state <= PRESSED;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
              state <= RELEASED;
              lvl_q <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= RELEASED;
        endcase
      end
    end
  end

  logic dir_press;
  logic clr_press;
  logic tc_d;
  logic tc_rise;

  assign dir_press  = press[0];
  assign clr_press  = press[1];
  assign btn_dir_db = db_lvl[0];
  assign btn_clr_db = db_lvl[1];
  assign tc_rise    = tc & ~tc_d;

  // Clear press beats a direction press, which beats an auto-reverse; a
  // direction press coinciding with a tc edge therefore toggles only once
  // and is not counted as an auto-reversal.
  always_ff @(posedge clk) begin
    if (clr) begin
      tc_d    <= 1'b0;
      mode    <= MODE_INIT;
      cnt_clr <= 1'b1;
      rev_cnt <= '0;
    end else begin
      tc_d    <= tc;
      cnt_clr <= clr_press;
      if (clr_press) begin
        mode    <= MODE_INIT;
        rev_cnt <= '0;
      end else if (dir_press) begin
        mode <= ~mode;
      end else if (auto_rev && tc_rise) begin
        mode <= ~mode;
        if (rev_cnt != 8'hFF) rev_cnt <= rev_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_count_dir_ctrl.sv
// ---------------------------------------------------------------------------
// tb_count_dir_ctrl
//
// Scoreboard bench for count_dir_ctrl. The stimulus process keeps a model of
// the expected output vector; whenever it drives something that will change
// the outputs it pushes the expected vector together with the clock edge
// after which it must appear. A separate monitor samples the outputs on the
// falling edge and, whenever the output vector changes, pops the next
// expectation and compares both value and timing. Any change with nothing
// expected is a failure, as is any expectation left over at the end.
// A small 4-bit counter model (holding at its terminal count) provides a live
// tc for the ping-pong scenario; otherwise tc is driven directly.
// ---------------------------------------------------------------------------
module tb_count_dir_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       btn_dir;
  logic       btn_clr;
  logic       auto_rev;
  logic       tc;
  logic       mode;
  logic       cnt_clr;
  logic       btn_dir_db;
  logic       btn_clr_db;
  logic [7:0] rev_cnt;

  count_dir_ctrl dut (
    .clk        (clk),
    .clr        (clr),
    .btn_dir    (btn_dir),
    .btn_clr    (btn_clr),
    .auto_rev   (auto_rev),
    .tc         (tc),
    .mode       (mode),
    .cnt_clr    (cnt_clr),
    .btn_dir_db (btn_dir_db),
    .btn_clr_db (btn_clr_db),
    .rev_cnt    (rev_cnt)
  );

  always #5 clk = ~clk;

  // Edge counter: after the Nth rising edge cyc == N.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream counter model providing a live tc.
  logic       cnt_en;
  logic       tc_man;
  logic [3:0] cnt = 4'd0;
  logic       tc_live;

  assign tc_live = mode ? (cnt == 4'd0) : (cnt == 4'hF);
  assign tc      = cnt_en ? tc_live : tc_man;

  always @(posedge clk) begin
    if (cnt_clr)                  cnt <= 4'd0;
    else if (cnt_en && !tc_live)  cnt <= mode ? cnt - 4'd1 : cnt + 4'd1;
  end

  typedef struct packed {
    logic       m;
    logic       cc;
    logic       dd;
    logic       cd;
    logic [7:0] rc;
  } snap_t;

  typedef struct {
    int    at;
    snap_t v;
    string name;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Expected-output model maintained by the stimulus process.
  logic       em, ecc, edd, ecd;
  logic [7:0] erc;

  function automatic string fmt(input snap_t s);
    return $sformatf("mode=%b cnt_clr=%b dir_db=%b clr_db=%b rev_cnt=%0d",
                     s.m, s.cc, s.dd, s.cd, s.rc);
  endfunction

  task automatic push(input int at, input string name);
    exp_t e;
    e.at   = at;
    e.v    = {em, ecc, edd, ecd, erc};
    e.name = name;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare on every change of the output vector.
  initial begin
    snap_t prev;
    snap_t cur;
    exp_t  e;
    prev = 'x;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        cur = {mode, cnt_clr, btn_dir_db, btn_clr_db, rev_cnt};
        if (cur !== prev) begin
          tests++;
          if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_change at cyc %0d: got %s, want no change",
                     cyc, fmt(cur));
          end else begin
            e = q.pop_front();
            if (e.at != cyc || cur !== e.v) begin
              fails++;
              $display("FAIL %s: got %s at cyc %0d, want %s at cyc %0d",
                       e.name, fmt(cur), cyc, fmt(e.v), e.at);
            end
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    int t;
    clr = 1'b1; btn_dir = 1'b0; btn_clr = 1'b0; auto_rev = 1'b0;
    tc_man = 1'b0; cnt_en = 1'b0;

    // Reset state, then cnt_clr drops on the first edge with clr low.
    em = 1'b0; ecc = 1'b1; edd = 1'b0; ecd = 1'b0; erc = 8'd0;
    push(1, "reset_state");
    tick(2);
    clr = 1'b0; ecc = 1'b0;
    push(3, "cnt_clr_after_reset");
    tick(3);

    // Direction press: level after 6 edges, toggle one edge later; release
    // is symmetric; a second press toggles back.
    for (int k = 0; k < 2; k++) begin
      t = cyc; btn_dir = 1'b1;
      edd = 1'b1; push(t + 6, "dir_db_rise");
      em = ~em;   push(t + 7, "dir_toggle");
      tick(20);
      t = cyc; btn_dir = 1'b0;
      edd = 1'b0; push(t + 6, "dir_db_fall");
      tick(20);
    end

    // Bounce shorter than the debounce window: no event at all.
    for (int k = 0; k < 2; k++) begin
      btn_dir = 1'b1; tick(2);
      btn_dir = 1'b0; tick(2);
    end
    tick(20);

    // Ping-pong with the live counter: up to 15, reverse, down to 0, reverse.
    t = cyc; auto_rev = 1'b1; cnt_en = 1'b1;
    em = 1'b1; erc = 8'd1; push(t + 16, "auto_rev_at_15");
    em = 1'b0; erc = 8'd2; push(t + 32, "auto_rev_at_0");
    tick(33);
    cnt_en = 1'b0;
    tick(3);

    // tc held high for 5 cycles: exactly one reversal.
    t = cyc; tc_man = 1'b1;
    em = 1'b1; erc = 8'd3; push(t + 1, "tc_hold_single_toggle");
    tick(5);
    tc_man = 1'b0;
    tick(3);

    // tc edge with auto_rev low, then auto_rev raised while tc stays high.
    auto_rev = 1'b0; tick(1);
    tc_man = 1'b1;   tick(3);
    auto_rev = 1'b1; tick(3);
    tc_man = 1'b0;   tick(2);

    // Direction press coincident with a tc rising edge: one toggle, no count.
    t = cyc; btn_dir = 1'b1;
    edd = 1'b1; push(t + 6, "dir_db_rise_coincident");
    em = 1'b0;  push(t + 7, "dir_and_tc_single_toggle");
    tick(6);
    tc_man = 1'b1; tick(4);
    tc_man = 1'b0; tick(10);
    t = cyc; btn_dir = 1'b0;
    edd = 1'b0; push(t + 6, "dir_db_fall_coincident");
    tick(20);

    // One more direction press to get mode=1 with rev_cnt=3.
    t = cyc; btn_dir = 1'b1;
    edd = 1'b1; push(t + 6, "dir_db_rise_pre_clear");
    em = 1'b1;  push(t + 7, "dir_toggle_pre_clear");
    tick(20);
    t = cyc; btn_dir = 1'b0;
    edd = 1'b0; push(t + 6, "dir_db_fall_pre_clear");
    tick(20);

    // Clear button held: mode/rev_cnt cleared, cnt_clr a single pulse.
    t = cyc; btn_clr = 1'b1;
    ecd = 1'b1; push(t + 6, "clr_db_rise");
    em = 1'b0; erc = 8'd0; ecc = 1'b1; push(t + 7, "clr_press_effect");
    ecc = 1'b0; push(t + 8, "cnt_clr_one_cycle");
    tick(20);
    t = cyc; btn_clr = 1'b0;
    ecd = 1'b0; push(t + 6, "clr_db_fall");
    tick(20);

    // Reset in the middle of a debounce: full requalification afterwards.
    t = cyc; btn_dir = 1'b1;
    tick(4);
    clr = 1'b1; ecc = 1'b1; push(t + 5, "reset_mid_debounce");
    tick(2);
    clr = 1'b0; ecc = 1'b0; push(t + 7, "reset_release");
    edd = 1'b1; push(t + 12, "requalify_db_rise");
    em = 1'b1;  push(t + 13, "requalify_toggle");
    tick(14);
    t = cyc; btn_dir = 1'b0;
    edd = 1'b0; push(t + 6, "requalify_db_fall");
    tick(20);

    // 256 auto-reversals: rev_cnt saturates at 255, mode keeps toggling.
    for (int i = 0; i < 256; i++) begin
      t = cyc; tc_man = 1'b1;
      em = ~em;
      if (erc != 8'hFF) erc = erc + 8'd1;
      push(t + 1, (i >= 254) ? "rev_cnt_saturation" : "rev_cnt_step");
      tick(1);
      tc_man = 1'b0;
      tick(1);
    end
    tick(5);

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_events: got %0d outstanding, want 0 (next %s)",
               q.size(), q[0].name);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
